// File: rtl/game_369_pkg.sv
// Shared types and sequence helpers for the 369 referee.
package game_369_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   localparam logic [3:0] SEQ_0  = 4'd0;
   localparam logic [3:0] SEQ_3  = 4'd3;
   localparam logic [3:0] SEQ_6  = 4'd6;
   localparam logic [3:0] SEQ_9  = 4'd9;
   localparam logic [3:0] SEQ_13 = 4'd13;

   // Every nonzero value in the sequence contains a 3, 6 or 9.
   function automatic logic expected_clap(input logic [3:0] c);
      return c != SEQ_0;
   endfunction

   function automatic logic [3:0] next_369(input logic [3:0] c);
      case (c)
         SEQ_0:   return SEQ_3;
         SEQ_3:   return SEQ_6;
         SEQ_6:   return SEQ_9;
         SEQ_9:   return SEQ_13;
         SEQ_13:  return SEQ_6;
         default: return SEQ_0;
      endcase
   endfunction

endpackage

// File: rtl/game_369_referee_if.sv
// Player-side answers in, turn/score/result out.
interface game_369_referee_if #(parameter int N_PLAYERS = 4);
   logic [N_PLAYERS-1:0] resp_valid;
   logic [N_PLAYERS-1:0] resp_clap;
   logic [N_PLAYERS-1:0] turn;
   logic [3:0]           count;
   logic [N_PLAYERS-1:0] alive;
   logic                 ok_pulse;
   logic                 fail_pulse;
   logic                 done;
   logic [N_PLAYERS-1:0] winner;

   modport master (
      output resp_valid, resp_clap,
      input  turn, count, alive, ok_pulse, fail_pulse, done, winner
   );

   modport slave (
      input  resp_valid, resp_clap,
      output turn, count, alive, ok_pulse, fail_pulse, done, winner
   );
endinterface

// File: rtl/counter_369_en.sv
// 4-bit 369 sequence register with clear and advance enable.
module counter_369_en
   import game_369_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       advance,
   output logic [3:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= SEQ_0;
      else if (advance)
         count <= next_369(count);
   end

endmodule

// File: rtl/game_369_referee.sv
// Grants turns round-robin, judges answers against the 369 count, tracks survivors.
module game_369_referee
   import game_369_pkg::*;
#(
   parameter int N_PLAYERS = 4,
   parameter int TIMEOUT   = 8
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   game_369_referee_if.slave   bus
);

   localparam int CW = $clog2(N_PLAYERS);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t               state;
   logic [N_PLAYERS-1:0] alive_q, alive_nxt;
   logic [CW-1:0]        cur, nxt;
   logic [TW-1:0]        timer;
   logic [N_PLAYERS-1:0] turn_q, winner_q;
   logic                 ok_q, fail_q, done_q;
   logic [3:0]           count;
   logic                 hit, expired, judged, correct, start_ok;

   counter_369_en u_counter (
      .clk     (clk),
      .reset   (reset),
      .clear   (start_ok),
      .advance (judged),
      .count   (count)
   );

   always_comb begin
      start_ok = start && (state == IDLE || state == DONE);
      hit      = bus.resp_valid[cur];
      expired  = timer == TW'(TIMEOUT - 1);
      judged   = (state == PLAY) && (hit || expired);
      correct  = hit && (bus.resp_clap[cur] == expected_clap(count));
      alive_nxt = alive_q;
      if (judged && !correct)
         alive_nxt[cur] = 1'b0;
      // Scan downward so the nearest alive index after cur wins.
      nxt = cur;
      for (int i = N_PLAYERS - 1; i >= 1; i--) begin
         if (alive_nxt[(int'(cur) + i) % N_PLAYERS])
            nxt = CW'((int'(cur) + i) % N_PLAYERS);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         alive_q  <= '1;
         cur      <= '0;
         timer    <= '0;
         turn_q   <= '0;
         winner_q <= '0;
         ok_q     <= 1'b0;
         fail_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         ok_q   <= 1'b0;
         fail_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= PLAY;
                  alive_q  <= '1;
                  cur      <= '0;
                  timer    <= '0;
                  turn_q   <= N_PLAYERS'(1);
                  winner_q <= '0;
                  done_q   <= 1'b0;
               end
            end
            PLAY: begin
               if (judged) begin
                  ok_q    <= correct;
                  fail_q  <= !correct;
                  alive_q <= alive_nxt;
                  timer   <= '0;
                  if ($onehot(alive_nxt)) begin
                     state    <= DONE;
                     done_q   <= 1'b1;
                     winner_q <= alive_nxt;
                     turn_q   <= '0;
                  end else begin
                     cur    <= nxt;
                     turn_q <= N_PLAYERS'(1) << nxt;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.turn       = turn_q;
   assign bus.count      = count;
   assign bus.alive      = alive_q;
   assign bus.ok_pulse   = ok_q;
   assign bus.fail_pulse = fail_q;
   assign bus.done       = done_q;
   assign bus.winner     = winner_q;

endmodule

// File: tb/tb_game_369_referee.sv
// Scoreboard bench: a behavioural model queues per-edge expectations, a monitor checks them.
module tb_game_369_referee;
   import game_369_pkg::*;

   localparam int TO = 8;

   typedef struct {
      logic       ok;
      logic       fail;
      logic [3:0] count;
      logic [3:0] turn;
      logic [3:0] alive;
      logic       done;
      logic [3:0] winner;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   int   total = 0;
   int   bad = 0;

   game_369_referee_if #(.N_PLAYERS(4)) bus ();

   game_369_referee #(.N_PLAYERS(4), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t   sb[$];
   exp_t   mon_e;
   state_t m_state = IDLE;
   logic [3:0] m_count = 4'd0;
   logic [3:0] m_alive = 4'hf;
   logic [3:0] m_win = 4'd0;
   logic [1:0] m_cur = 2'd0;
   logic [1:0] m_k;
   int         m_timer = 0;

   function automatic logic [3:0] seq_step(input logic [3:0] c);
      logic [3:0] r;
      r = 4'd0;
      if (c == 4'd0) r = 4'd3;
      if (c == 4'd3) r = 4'd6;
      if (c == 4'd6) r = 4'd9;
      if (c == 4'd9) r = 4'd13;
      if (c == 4'd13) r = 4'd6;
      return r;
   endfunction

   // One cycle of stimulus; the model predicts the outputs after the next edge.
   task automatic drive(input logic rst, input logic st, input logic [3:0] v, input logic [3:0] c);
      exp_t e;
      logic want_clap, good, found;
      @(negedge clk);
      reset = rst; start = st; bus.resp_valid = v; bus.resp_clap = c;
      e.ok = 1'b0; e.fail = 1'b0;
      if (rst) begin
         m_state = IDLE; m_count = 0; m_alive = 4'hf; m_cur = 0; m_timer = 0; m_win = 0;
      end else if (m_state != PLAY) begin
         if (st) begin
            m_state = PLAY; m_count = 0; m_alive = 4'hf; m_cur = 0; m_timer = 0; m_win = 0;
         end
      end else if (v[m_cur] || m_timer == TO - 1) begin
         want_clap = (m_count != 4'd0);
         good = v[m_cur] && (c[m_cur] == want_clap);
         e.ok = good; e.fail = !good;
         if (!good) m_alive[m_cur] = 1'b0;
         m_count = seq_step(m_count);
         m_timer = 0;
         if ($countones(m_alive) == 1) begin
            m_state = DONE; m_win = m_alive;
         end else begin
            found = 1'b0;
            for (int i = 1; i <= 4; i++) begin
               m_k = m_cur + 2'(i);
               if (!found && m_alive[m_k]) begin
                  found = 1'b1;
                  m_cur = m_k;
               end
            end
         end
      end else begin
         m_timer++;
      end
      e.count  = m_count;
      e.alive  = m_alive;
      e.turn   = (m_state == PLAY) ? (4'd1 << m_cur) : 4'd0;
      e.done   = (m_state == DONE);
      e.winner = (m_state == DONE) ? m_win : 4'd0;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         total += 7;
         if (bus.ok_pulse !== mon_e.ok) begin bad++; $display("FAIL sb_ok got=%0b want=%0b t=%0t", bus.ok_pulse, mon_e.ok, $time); end
         if (bus.fail_pulse !== mon_e.fail) begin bad++; $display("FAIL sb_fail got=%0b want=%0b t=%0t", bus.fail_pulse, mon_e.fail, $time); end
         if (bus.count !== mon_e.count) begin bad++; $display("FAIL sb_count got=%0d want=%0d t=%0t", bus.count, mon_e.count, $time); end
         if (bus.turn !== mon_e.turn) begin bad++; $display("FAIL sb_turn got=%b want=%b t=%0t", bus.turn, mon_e.turn, $time); end
         if (bus.alive !== mon_e.alive) begin bad++; $display("FAIL sb_alive got=%b want=%b t=%0t", bus.alive, mon_e.alive, $time); end
         if (bus.done !== mon_e.done) begin bad++; $display("FAIL sb_done got=%0b want=%0b t=%0t", bus.done, mon_e.done, $time); end
         if (bus.winner !== mon_e.winner) begin bad++; $display("FAIL sb_winner got=%b want=%b t=%0t", bus.winner, mon_e.winner, $time); end
      end
   end

   task automatic settle();
      @(posedge clk); #2;
   endtask

   task automatic test_reset();
      drive(1, 0, 4'b0, 4'b0);
      drive(1, 0, 4'b0, 4'b0);
      settle();
      total++;
      if ({bus.count, bus.alive, bus.turn, bus.done} !== {4'd0, 4'hf, 4'd0, 1'b0}) begin
         bad++; $display("FAIL reset_state got=%h want=%h", {bus.count, bus.alive, bus.turn, bus.done}, {4'd0, 4'hf, 4'd0, 1'b0});
      end
   endtask

   task automatic test_basic();
      drive(0, 1, 4'b0, 4'b0);
      drive(0, 0, 4'b0001, 4'b0000);
      settle();
      total++;
      if ({bus.ok_pulse, bus.count, bus.turn} !== {1'b1, 4'd3, 4'b0010}) begin
         bad++; $display("FAIL basic_ok got=%h want=%h", {bus.ok_pulse, bus.count, bus.turn}, {1'b1, 4'd3, 4'b0010});
      end
   endtask

   task automatic test_wrong();
      drive(0, 0, 4'b0010, 4'b0000);
      settle();
      total++;
      if ({bus.fail_pulse, bus.alive, bus.count, bus.turn} !== {1'b1, 4'b1101, 4'd6, 4'b0100}) begin
         bad++; $display("FAIL wrong_answer got=%h want=%h", {bus.fail_pulse, bus.alive, bus.count, bus.turn}, {1'b1, 4'b1101, 4'd6, 4'b0100});
      end
      drive(0, 0, 4'b0000, 4'b0000);
      drive(0, 0, 4'b0100, 4'b0100);
      drive(0, 0, 4'b1000, 4'b1000);
      settle();
      total++;
      if (bus.turn !== 4'b0001) begin bad++; $display("FAIL skip_dead got=%b want=0001", bus.turn); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < TO; i++) drive(0, 0, 4'b0000, 4'b0000);
      settle();
      total++;
      if ({bus.fail_pulse, bus.alive, bus.turn} !== {1'b1, 4'b1100, 4'b0100}) begin
         bad++; $display("FAIL timeout got=%h want=%h", {bus.fail_pulse, bus.alive, bus.turn}, {1'b1, 4'b1100, 4'b0100});
      end
      for (int i = 0; i < TO - 1; i++) drive(0, 0, 4'b0000, 4'b0000);
      drive(0, 0, 4'b0100, 4'b0100);
      settle();
      total++;
      if ({bus.ok_pulse, bus.fail_pulse, bus.count} !== {1'b1, 1'b0, 4'd9}) begin
         bad++; $display("FAIL last_edge_answer got=%h want=%h", {bus.ok_pulse, bus.fail_pulse, bus.count}, {1'b1, 1'b0, 4'd9});
      end
   endtask

   task automatic test_ignore();
      drive(0, 0, 4'b0101, 4'b0000);
      drive(0, 0, 4'b1111, 4'b1000);
      settle();
      total++;
      if ({bus.ok_pulse, bus.alive, bus.count} !== {1'b1, 4'b1100, 4'd13}) begin
         bad++; $display("FAIL ignore_others got=%h want=%h", {bus.ok_pulse, bus.alive, bus.count}, {1'b1, 4'b1100, 4'd13});
      end
   endtask

   task automatic test_done();
      drive(0, 0, 4'b0100, 4'b0100);
      drive(0, 0, 4'b1000, 4'b0000);
      settle();
      total++;
      if ({bus.done, bus.winner, bus.turn, bus.fail_pulse} !== {1'b1, 4'b0100, 4'd0, 1'b1}) begin
         bad++; $display("FAIL enter_done got=%h want=%h", {bus.done, bus.winner, bus.turn, bus.fail_pulse}, {1'b1, 4'b0100, 4'd0, 1'b1});
      end
      drive(0, 0, 4'b0100, 4'b0100);
      drive(0, 0, 4'b0000, 4'b0000);
   endtask

   task automatic test_restart();
      drive(0, 1, 4'b0000, 4'b0000);
      settle();
      total++;
      if ({bus.count, bus.alive, bus.turn, bus.done, bus.winner} !== {4'd0, 4'hf, 4'b0001, 1'b0, 4'd0}) begin
         bad++; $display("FAIL restart got=%h want=%h", {bus.count, bus.alive, bus.turn, bus.done, bus.winner}, {4'd0, 4'hf, 4'b0001, 1'b0, 4'd0});
      end
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 4'b0001, 4'b0000);
      drive(0, 1, 4'b0010, 4'b0010);
      drive(0, 0, 4'b0100, 4'b0100);
      drive(0, 1, 4'b0000, 4'b0000);
      settle();
      total++;
      if ({bus.count, bus.turn} !== {4'd9, 4'b1000}) begin
         bad++; $display("FAIL start_in_play got=%h want=%h", {bus.count, bus.turn}, {4'd9, 4'b1000});
      end
      drive(1, 0, 4'b1000, 4'b1000);
      settle();
      total++;
      if ({bus.count, bus.alive, bus.turn, bus.ok_pulse} !== {4'd0, 4'hf, 4'd0, 1'b0}) begin
         bad++; $display("FAIL reset_mid got=%h want=%h", {bus.count, bus.alive, bus.turn, bus.ok_pulse}, {4'd0, 4'hf, 4'd0, 1'b0});
      end
      drive(0, 0, 4'b0001, 4'b0000);
      drive(0, 0, 4'b0000, 4'b0000);
   endtask

   initial begin
      bus.resp_valid = '0;
      bus.resp_clap  = '0;
      test_reset();
      test_basic();
      test_wrong();
      test_timeout();
      test_ignore();
      test_done();
      test_restart();
      test_reset_mid();
      settle();
      settle();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
